retire_stage: RTL and testbench
===============================

RETIRE_STAGE -- requirements
Module: retire_stage

Interface
REQ-001 Parameters are macros only: `SUPERSCALAR_WAYS` (retire width), `N_ARCH_REGS` = 32, `N_PHYS_REG_BITS` (physical register index width), `XLEN` = 32.
REQ-002 clock  input  1  sole clock; all state updates on posedge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 rob_retire_in  input  ROB_PACKET[`SUPERSCALAR_WAYS]  per-way retiring entry from ROB; an all-zero packet means no retire.
REQ-005 free_out  output  FREE_PACKET[`SUPERSCALAR_WAYS]  {valid, pr_idx}, the told_idx returned to the free list.
REQ-006 arch_map_out  output  [`N_ARCH_REGS][`N_PHYS_REG_BITS]  architectural map table.
REQ-007 flush  output  1  pipeline squash request.
REQ-008 flush_pc  output  [`XLEN]  redirect PC, valid while flush=1.
REQ-009 halted  output  1  processor halted, sticky.
REQ-010 retire_cnt  output  [64]  total instructions retired.

Function
REQ-011 Way i retires iff rob_retire_in[i].complete=1, state=RUN, and no lower way j<i in the same cycle has precise_state_enable=1 or halt=1.
REQ-012 States: RUN, FLUSH, HALTED.
- RUN->FLUSH: a retiring way has precise_state_enable=1 and halt=0.
- RUN->HALTED: a retiring way has halt=1; halt outranks flush.
- FLUSH->RUN: after exactly one cycle.
- HALTED: absorbing until reset.
REQ-013 In FLUSH and HALTED, all inputs are ignored: no map update, no free, no count.
REQ-014 flush=1 for exactly the one cycle the FSM is in FLUSH.
REQ-015 flush_pc = target_pc of the triggering way, registered; it is 0 when flush=0.
REQ-016 halted=1 from the cycle after the halt instruction retires.
REQ-017 Map update: for each retiring way with ar_idx≠0, arch_map[ar_idx] <= t_idx, visible the next cycle.
REQ-018 If several ways write the same ar_idx in one cycle, the highest way index wins.
REQ-019 ar_idx=0 never updates the map, and arch_map[0] stays 0.
REQ-020 Free return: free_out[i].valid=1 and pr_idx=told_idx for each retiring way with ar_idx≠0. This output is registered, with 1-cycle latency.
REQ-021 The triggering flush or halt instruction itself retires (map, free, count), and younger ways are dropped.
REQ-022 retire_cnt += number of retiring ways each cycle; it wraps modulo 2^64.

Reset
REQ-023 Reset state:
- state=RUN
- arch_map[r]=r for every r
- free_out all zero
- flush=0, flush_pc=0
- halted=0
- retire_cnt=0
REQ-024 Reset asserted mid-FLUSH or in HALTED returns to RUN the next cycle, and same-cycle inputs are discarded.

Configuration
REQ-025 Macro RETIRE_TRACE_EN, when defined, adds output retire_trace [`SUPERSCALAR_WAYS] {valid, NPC, ar_idx, dest_value}:
- registered alongside free_out
- valid mirrors retirement
- reset value 0
REQ-026 Without RETIRE_TRACE_EN the port and its logic are absent, and all other behaviour is identical.

Structure
REQ-027 The shared package holds FREE_PACKET, RETIRE_TRACE_PACKET, and the RETIRE_STATE enum; ROB_PACKET is reused unchanged.
REQ-028 One sub-module, retire_arch_map, holds the map table with per-way ordered write ports. Retire selection and the FSM stay in retire_stage.

Verification
REQ-029 The bench covers the following directed scenarios:
- Reset, then idle: arch_map[5]=5, flush=0, halted=0, retire_cnt=0.
- Way0 {ar=3, t=40, told=3} and way1 {ar=3, t=41, told=40} retire in one cycle. Next cycle: arch_map[3]=41; free_out pr_idx 3 and 40 valid; retire_cnt=2.
- Way0 branch with precise_state_enable=1, target_pc=0x1000; way1 complete. Next cycle: flush=1, flush_pc=0x1000, way1 not counted. The following cycle: flush=0.
- Way0 ar_idx=0 retires: no map change, free_out[0].valid=0, retire_cnt+1.
- Halt retires, then valid packets follow for 3 cycles: halted=1 stays high, retire_cnt is frozen. After reset: halted=0.
- With RETIRE_TRACE_EN, NPC=0x24, ar=7, value=0xdead retires: retire_trace[0]={1,0x24,7,0xdead} next cycle.

Source files
------------

// File: rtl/retire_stage_pkg.sv
// Shared types and width macros for the retire stage.
// Optional feature: define RETIRE_TRACE_EN to add the per-way retire_trace output.
`ifndef SUPERSCALAR_WAYS
`define SUPERSCALAR_WAYS 2
`endif
`ifndef N_ARCH_REGS
`define N_ARCH_REGS 32
`endif
`ifndef N_PHYS_REG_BITS
`define N_PHYS_REG_BITS 6
`endif
`ifndef XLEN
`define XLEN 32
`endif

package retire_stage_pkg;

    localparam int unsigned Ways      = `SUPERSCALAR_WAYS;
    localparam int unsigned NArchRegs = `N_ARCH_REGS;
    localparam int unsigned PhysW     = `N_PHYS_REG_BITS;
    localparam int unsigned Xlen      = `XLEN;
    localparam int unsigned ArchW     = $clog2(NArchRegs);

    typedef struct packed {
        logic             complete;
        logic             precise_state_enable;
        logic             halt;
        logic [Xlen-1:0]  target_pc;
        logic [Xlen-1:0]  NPC;
        logic [ArchW-1:0] ar_idx;
        logic [PhysW-1:0] t_idx;
        logic [PhysW-1:0] told_idx;
        logic [Xlen-1:0]  dest_value;
    } ROB_PACKET;

    typedef struct packed {
        logic             valid;
        logic [PhysW-1:0] pr_idx;
    } FREE_PACKET;

    typedef struct packed {
        logic             valid;
        logic [Xlen-1:0]  NPC;
        logic [ArchW-1:0] ar_idx;
        logic [Xlen-1:0]  dest_value;
    } RETIRE_TRACE_PACKET;

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StHalted
    } RETIRE_STATE;

endpackage

// File: rtl/retire_stage_if.sv
// Bundle of retire-stage signals; master is the retire stage, slave is the ROB/consumer side.
// retire_trace exists only when RETIRE_TRACE_EN is defined.
interface retire_stage_if;
    import retire_stage_pkg::*;

    ROB_PACKET  [Ways-1:0]                 rob_retire_in;
    FREE_PACKET [Ways-1:0]                 free_out;
    logic       [NArchRegs-1:0][PhysW-1:0] arch_map_out;
    logic                                  flush;
    logic       [Xlen-1:0]                 flush_pc;
    logic                                  halted;
    logic       [63:0]                     retire_cnt;
`ifdef RETIRE_TRACE_EN
    RETIRE_TRACE_PACKET [Ways-1:0]         retire_trace;
`endif

    modport master (
`ifdef RETIRE_TRACE_EN
        output retire_trace,
`endif
        input  rob_retire_in,
        output free_out,
        output arch_map_out,
        output flush,
        output flush_pc,
        output halted,
        output retire_cnt
    );

    modport slave (
`ifdef RETIRE_TRACE_EN
        input  retire_trace,
`endif
        output rob_retire_in,
        input  free_out,
        input  arch_map_out,
        input  flush,
        input  flush_pc,
        input  halted,
        input  retire_cnt
    );

endinterface

// File: rtl/retire_arch_map.sv
// Architectural map table with ordered per-way write ports; higher way index wins on conflict.
// Register 0 is hardwired to physical 0 and never written.
module retire_arch_map
    import retire_stage_pkg::*;
(
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [Ways-1:0]                      we_i,
    input  logic [Ways-1:0][ArchW-1:0]           waddr_i,
    input  logic [Ways-1:0][PhysW-1:0]           wdata_i,
    output logic [NArchRegs-1:0][PhysW-1:0]      map_o
);

    logic [NArchRegs-1:0][PhysW-1:0] map_q, map_d;

    always_comb begin
        map_d = map_q;
        for (int i = 0; i < Ways; i++) begin
            if (we_i[i] && (waddr_i[i] != '0)) begin
                map_d[waddr_i[i]] = wdata_i[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NArchRegs; r++) begin
                map_q[r] <= PhysW'(r);
            end
        end else begin
            map_q <= map_d;
        end
    end

    assign map_o = map_q;

endmodule

// File: rtl/retire_stage.sv
// Retire stage: in-order retire selection, RUN/FLUSH/HALTED control, free-list return, counter.
// Define RETIRE_TRACE_EN to add the registered retire_trace output.
module retire_stage
    import retire_stage_pkg::*;
(
    input logic            clock,
    input logic            reset,
    retire_stage_if.master bus
);

    RETIRE_STATE                state_q, state_d;
    logic [Ways-1:0]            retire;
    logic                       blocked;
    logic                       halt_hit, flush_hit;
    logic [Xlen-1:0]            trigger_pc;
    logic [Xlen-1:0]            flush_pc_q, flush_pc_d;
    logic [63:0]                retire_cnt_q, retire_cnt_d;
    FREE_PACKET [Ways-1:0]      free_q, free_d;
    logic [Ways-1:0]            map_we;
    logic [Ways-1:0][ArchW-1:0] map_waddr;
    logic [Ways-1:0][PhysW-1:0] map_wdata;

    // A flush or halt at way j stops every younger way, whether or not way j itself completes.
    always_comb begin
        retire     = '0;
        blocked    = 1'b0;
        halt_hit   = 1'b0;
        flush_hit  = 1'b0;
        trigger_pc = '0;
        for (int i = 0; i < Ways; i++) begin
            retire[i] = bus.rob_retire_in[i].complete && (state_q == StRun) && !blocked;
            if (retire[i] && bus.rob_retire_in[i].halt) begin
                halt_hit = 1'b1;
            end else if (retire[i] && bus.rob_retire_in[i].precise_state_enable) begin
                flush_hit  = 1'b1;
                trigger_pc = bus.rob_retire_in[i].target_pc;
            end
            if (bus.rob_retire_in[i].precise_state_enable || bus.rob_retire_in[i].halt) begin
                blocked = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (halt_hit) begin
                    state_d = StHalted;
                end else if (flush_hit) begin
                    state_d = StFlush;
                end
            end
            StFlush:  state_d = StRun;
            StHalted: state_d = StHalted;
            default:  state_d = StRun;
        endcase
    end

    always_comb begin
        flush_pc_d   = flush_hit ? trigger_pc : '0;
        retire_cnt_d = retire_cnt_q;
        free_d       = '0;
        map_we       = '0;
        map_waddr    = '0;
        map_wdata    = '0;
        for (int i = 0; i < Ways; i++) begin
            map_waddr[i] = bus.rob_retire_in[i].ar_idx;
            map_wdata[i] = bus.rob_retire_in[i].t_idx;
            if (retire[i]) begin
                retire_cnt_d = retire_cnt_d + 64'd1;
                if (bus.rob_retire_in[i].ar_idx != '0) begin
                    map_we[i]        = 1'b1;
                    free_d[i].valid  = 1'b1;
                    free_d[i].pr_idx = bus.rob_retire_in[i].told_idx;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StRun;
            flush_pc_q   <= '0;
            retire_cnt_q <= '0;
            free_q       <= '0;
        end else begin
            state_q      <= state_d;
            flush_pc_q   <= flush_pc_d;
            retire_cnt_q <= retire_cnt_d;
            free_q       <= free_d;
        end
    end

    retire_arch_map u_arch_map (
        .clk_i   (clock),
        .rst_i   (reset),
        .we_i    (map_we),
        .waddr_i (map_waddr),
        .wdata_i (map_wdata),
        .map_o   (bus.arch_map_out)
    );

`ifdef RETIRE_TRACE_EN
    RETIRE_TRACE_PACKET [Ways-1:0] trace_q, trace_d;

    always_comb begin
        trace_d = '0;
        for (int i = 0; i < Ways; i++) begin
            trace_d[i].valid      = retire[i];
            trace_d[i].NPC        = bus.rob_retire_in[i].NPC;
            trace_d[i].ar_idx     = bus.rob_retire_in[i].ar_idx;
            trace_d[i].dest_value = bus.rob_retire_in[i].dest_value;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            trace_q <= '0;
        end else begin
            trace_q <= trace_d;
        end
    end

    assign bus.retire_trace = trace_q;
`else
    // Trace-only packet fields have no consumer in this build.
    logic unused_trace_fields;
    always_comb begin
        unused_trace_fields = 1'b0;
        for (int i = 0; i < Ways; i++) begin
            unused_trace_fields = unused_trace_fields ^
                (^{bus.rob_retire_in[i].NPC, bus.rob_retire_in[i].dest_value});
        end
    end
`endif

    assign bus.free_out   = free_q;
    assign bus.flush      = (state_q == StFlush);
    assign bus.flush_pc   = flush_pc_q;
    assign bus.halted     = (state_q == StHalted);
    assign bus.retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_retire_stage.sv
// Bench for retire_stage: directed scenarios plus randomized traffic checked against a
// sequential reference model. Define RETIRE_TRACE_EN to also exercise retire_trace.
module tb_retire_stage;
    import retire_stage_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    retire_stage_if bus ();

    retire_stage dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the architectural effect of each cycle's retire group.
    logic [PhysW-1:0] m_map [NArchRegs];
    logic [63:0]      m_cnt;
    logic             m_in_flush;
    logic             m_halted;
    logic [Xlen-1:0]  m_flush_pc;
    FREE_PACKET       m_free [Ways];
`ifdef RETIRE_TRACE_EN
    RETIRE_TRACE_PACKET m_trace [Ways];
`endif

    function automatic ROB_PACKET mk(logic c, logic pse, logic h, int ar, int t, int told,
                                     logic [Xlen-1:0] tpc, logic [Xlen-1:0] npc,
                                     logic [Xlen-1:0] val);
        ROB_PACKET p;
        p.complete             = c;
        p.precise_state_enable = pse;
        p.halt                 = h;
        p.target_pc            = tpc;
        p.NPC                  = npc;
        p.ar_idx               = ArchW'(ar);
        p.t_idx                = PhysW'(t);
        p.told_idx             = PhysW'(told);
        p.dest_value           = val;
        return p;
    endfunction

    task automatic model_step(input ROB_PACKET [Ways-1:0] p, input logic rst);
        int  stop;
        bit  found;
        for (int i = 0; i < Ways; i++) begin
            m_free[i] = '0;
`ifdef RETIRE_TRACE_EN
            m_trace[i] = '0;
`endif
        end
        m_flush_pc = '0;
        if (rst) begin
            for (int r = 0; r < NArchRegs; r++) m_map[r] = PhysW'(r);
            m_cnt      = '0;
            m_in_flush = 1'b0;
            m_halted   = 1'b0;
            return;
        end
        if (m_halted) return;
        if (m_in_flush) begin
            m_in_flush = 1'b0;
            return;
        end
        // The group ends at the oldest way carrying a flush or halt marker.
        stop  = Ways - 1;
        found = 0;
        for (int j = 0; j < Ways; j++) begin
            if (!found && (p[j].precise_state_enable || p[j].halt)) begin
                stop  = j;
                found = 1;
            end
        end
        for (int i = 0; i <= stop; i++) begin
            if (p[i].complete) begin
                m_cnt = m_cnt + 1;
                if (p[i].ar_idx != 0) begin
                    m_map[p[i].ar_idx] = p[i].t_idx;
                    m_free[i].valid    = 1'b1;
                    m_free[i].pr_idx   = p[i].told_idx;
                end
`ifdef RETIRE_TRACE_EN
                m_trace[i] = {1'b1, p[i].NPC, p[i].ar_idx, p[i].dest_value};
`endif
                if (p[i].halt) begin
                    m_halted = 1'b1;
                end else if (p[i].precise_state_enable) begin
                    m_in_flush = 1'b1;
                    m_flush_pc = p[i].target_pc;
                end
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model, and land #1 after the edge.
    task automatic cycle(input ROB_PACKET [Ways-1:0] p, input logic rst);
        bus.rob_retire_in = p;
        reset             = rst;
        model_step(p, rst);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        ROB_PACKET [Ways-1:0] p;
        int bad_r;
        p = '0;
        cycle(p, 1'b1);
        cycle(p, 1'b1);
        cycle(p, 1'b0);
        n_tests++;
        if (bus.arch_map_out[5] !== PhysW'(5)) begin
            n_fail++;
            $display("FAIL reset_map5: got %0d want 5", bus.arch_map_out[5]);
        end
        bad_r = -1;
        for (int r = 0; r < NArchRegs; r++)
            if (bad_r < 0 && bus.arch_map_out[r] !== PhysW'(r)) bad_r = r;
        n_tests++;
        if (bad_r >= 0) begin
            n_fail++;
            $display("FAIL reset_map_identity: map[%0d]=%0d want %0d", bad_r,
                     bus.arch_map_out[bad_r], bad_r);
        end
        n_tests++;
        if (bus.flush !== 1'b0 || bus.flush_pc !== '0 || bus.halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: flush=%b pc=%h halted=%b want 0/0/0", bus.flush,
                     bus.flush_pc, bus.halted);
        end
        n_tests++;
        if (bus.retire_cnt !== 64'd0 || bus.free_out !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt_free: cnt=%0d free=%h want 0/0", bus.retire_cnt,
                     bus.free_out);
        end
    endtask

    task automatic test_same_dest();
        ROB_PACKET [Ways-1:0] p;
        FREE_PACKET e0, e1;
        p    = '0;
        p[0] = mk(1, 0, 0, 3, 40, 3, 0, 0, 0);
        p[1] = mk(1, 0, 0, 3, 41, 40, 0, 0, 0);
        e0   = '{valid: 1'b1, pr_idx: PhysW'(3)};
        e1   = '{valid: 1'b1, pr_idx: PhysW'(40)};
        cycle(p, 1'b0);
        n_tests++;
        if (bus.arch_map_out[3] !== PhysW'(41)) begin
            n_fail++;
            $display("FAIL same_dest_map: map[3]=%0d want 41", bus.arch_map_out[3]);
        end
        n_tests++;
        if (bus.free_out[0] !== e0 || bus.free_out[1] !== e1) begin
            n_fail++;
            $display("FAIL same_dest_free: got %h/%h want %h/%h", bus.free_out[0],
                     bus.free_out[1], e0, e1);
        end
        n_tests++;
        if (bus.retire_cnt !== 64'd2) begin
            n_fail++;
            $display("FAIL same_dest_cnt: got %0d want 2", bus.retire_cnt);
        end
    endtask

    task automatic test_flush();
        ROB_PACKET [Ways-1:0] p;
        logic [63:0] c0;
        c0   = m_cnt;
        p    = '0;
        p[0] = mk(1, 1, 0, 6, 12, 6, 32'h1000, 0, 0);
        p[1] = mk(1, 0, 0, 4, 20, 4, 0, 0, 0);
        cycle(p, 1'b0);
        n_tests++;
        if (bus.flush !== 1'b1 || bus.flush_pc !== 32'h1000) begin
            n_fail++;
            $display("FAIL flush_assert: flush=%b pc=%h want 1/1000", bus.flush, bus.flush_pc);
        end
        n_tests++;
        if (bus.retire_cnt !== c0 + 1 || bus.arch_map_out[6] !== PhysW'(12) ||
            bus.arch_map_out[4] !== PhysW'(4)) begin
            n_fail++;
            $display("FAIL flush_retire: cnt=%0d map6=%0d map4=%0d want %0d/12/4",
                     bus.retire_cnt, bus.arch_map_out[6], bus.arch_map_out[4], c0 + 1);
        end
        // Inputs presented during the flush cycle must be ignored.
        p    = '0;
        p[0] = mk(1, 0, 0, 8, 30, 8, 0, 0, 0);
        cycle(p, 1'b0);
        n_tests++;
        if (bus.flush !== 1'b0 || bus.flush_pc !== '0) begin
            n_fail++;
            $display("FAIL flush_release: flush=%b pc=%h want 0/0", bus.flush, bus.flush_pc);
        end
        n_tests++;
        if (bus.retire_cnt !== c0 + 1 || bus.free_out[0].valid !== 1'b0 ||
            bus.arch_map_out[8] !== PhysW'(8)) begin
            n_fail++;
            $display("FAIL flush_ignore: cnt=%0d free0=%b map8=%0d want %0d/0/8",
                     bus.retire_cnt, bus.free_out[0].valid, bus.arch_map_out[8], c0 + 1);
        end
    endtask

    task automatic test_zero_dest();
        ROB_PACKET [Ways-1:0] p;
        logic [63:0] c0;
        c0   = m_cnt;
        p    = '0;
        p[0] = mk(1, 0, 0, 0, 9, 9, 0, 0, 0);
        cycle(p, 1'b0);
        n_tests++;
        if (bus.arch_map_out[0] !== '0 || bus.free_out[0].valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_dest: map0=%0d free0=%b want 0/0", bus.arch_map_out[0],
                     bus.free_out[0].valid);
        end
        n_tests++;
        if (bus.retire_cnt !== c0 + 1) begin
            n_fail++;
            $display("FAIL zero_dest_cnt: got %0d want %0d", bus.retire_cnt, c0 + 1);
        end
    endtask

    task automatic test_halt();
        ROB_PACKET [Ways-1:0] p;
        logic [63:0] c0;
        FREE_PACKET e0;
        c0   = m_cnt;
        p    = '0;
        p[0] = mk(1, 0, 1, 2, 50, 2, 0, 0, 0);
        p[1] = mk(1, 0, 0, 5, 51, 5, 0, 0, 0);
        e0   = '{valid: 1'b1, pr_idx: PhysW'(2)};
        cycle(p, 1'b0);
        n_tests++;
        if (bus.halted !== 1'b1 || bus.retire_cnt !== c0 + 1 || bus.free_out[0] !== e0) begin
            n_fail++;
            $display("FAIL halt_retire: halted=%b cnt=%0d free0=%h want 1/%0d/%h", bus.halted,
                     bus.retire_cnt, bus.free_out[0], c0 + 1, e0);
        end
        n_tests++;
        if (bus.arch_map_out[2] !== PhysW'(50) || bus.arch_map_out[5] !== PhysW'(5)) begin
            n_fail++;
            $display("FAIL halt_map: map2=%0d map5=%0d want 50/5", bus.arch_map_out[2],
                     bus.arch_map_out[5]);
        end
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < Ways; i++) p[i] = mk(1, 0, 0, 9, 33 + i, 9, 0, 0, 0);
            cycle(p, 1'b0);
            n_tests++;
            if (bus.halted !== 1'b1 || bus.retire_cnt !== c0 + 1 || bus.free_out !== '0 ||
                bus.arch_map_out[9] !== PhysW'(9)) begin
                n_fail++;
                $display("FAIL halt_sticky[%0d]: halted=%b cnt=%0d free=%h map9=%0d", k,
                         bus.halted, bus.retire_cnt, bus.free_out, bus.arch_map_out[9]);
            end
        end
        // Reset while halted, with live inputs that must be discarded.
        cycle(p, 1'b1);
        n_tests++;
        if (bus.halted !== 1'b0 || bus.retire_cnt !== 64'd0 ||
            bus.arch_map_out[2] !== PhysW'(2)) begin
            n_fail++;
            $display("FAIL halt_reset: halted=%b cnt=%0d map2=%0d want 0/0/2", bus.halted,
                     bus.retire_cnt, bus.arch_map_out[2]);
        end
        p = '0;
        cycle(p, 1'b0);
    endtask

`ifdef RETIRE_TRACE_EN
    task automatic test_trace();
        ROB_PACKET [Ways-1:0] p;
        RETIRE_TRACE_PACKET e;
        p    = '0;
        p[0] = mk(1, 0, 0, 7, 14, 7, 0, 32'h24, 32'hdead);
        e    = '{valid: 1'b1, NPC: 32'h24, ar_idx: ArchW'(7), dest_value: 32'hdead};
        cycle(p, 1'b0);
        n_tests++;
        if (bus.retire_trace[0] !== e) begin
            n_fail++;
            $display("FAIL trace: got %h want %h", bus.retire_trace[0], e);
        end
    endtask
`endif

    task automatic test_random();
        ROB_PACKET [Ways-1:0] p;
        logic rst;
        int bad_r;
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < Ways; i++) begin
                p[i] = mk(($urandom_range(3) != 0), ($urandom_range(7) == 0),
                          ($urandom_range(31) == 0), $urandom_range(NArchRegs - 1),
                          $urandom_range((1 << PhysW) - 1), $urandom_range((1 << PhysW) - 1),
                          $urandom, $urandom, $urandom);
            end
            rst = m_halted ? ($urandom_range(2) == 0) : ($urandom_range(24) == 0);
            cycle(p, rst);
            bad_r = -1;
            for (int r = 0; r < NArchRegs; r++)
                if (bad_r < 0 && bus.arch_map_out[r] !== m_map[r]) bad_r = r;
            n_tests++;
            if (bad_r >= 0) begin
                n_fail++;
                $display("FAIL rand_map[%0d]: map[%0d]=%0d want %0d", k, bad_r,
                         bus.arch_map_out[bad_r], m_map[bad_r]);
            end
            for (int i = 0; i < Ways; i++) begin
                n_tests++;
                if (bus.free_out[i] !== m_free[i]) begin
                    n_fail++;
                    $display("FAIL rand_free[%0d] way %0d: got %h want %h", k, i,
                             bus.free_out[i], m_free[i]);
                end
`ifdef RETIRE_TRACE_EN
                n_tests++;
                if (bus.retire_trace[i] !== m_trace[i]) begin
                    n_fail++;
                    $display("FAIL rand_trace[%0d] way %0d: got %h want %h", k, i,
                             bus.retire_trace[i], m_trace[i]);
                end
`endif
            end
            n_tests++;
            if (bus.flush !== m_in_flush || bus.flush_pc !== m_flush_pc ||
                bus.halted !== m_halted || bus.retire_cnt !== m_cnt) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: flush=%b pc=%h halted=%b cnt=%0d want %b/%h/%b/%0d",
                         k, bus.flush, bus.flush_pc, bus.halted, bus.retire_cnt, m_in_flush,
                         m_flush_pc, m_halted, m_cnt);
            end
        end
    endtask

    initial begin
        bus.rob_retire_in = '0;
        test_reset();
        test_same_dest();
        test_flush();
        test_zero_dest();
        test_halt();
`ifdef RETIRE_TRACE_EN
        test_trace();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
